// File: rtl/mt9v034_seq_if.sv
// Pin-level bundle between the MT9V034 snapshot sequencer and its neighbours.
// The master side drives the requests and frame_valid; the sequencer (slave) drives the camera pins and status.
interface mt9v034_seq_if;
  // No valid/ready handshake on this bundle. rst_req is a level that is honoured
  // every clock it is high. trig_req is a level whose rising edge asks for one
  // frame. frame_valid is the raw sensor level. All status outputs are registered.
  logic        rst_req;
  logic        trig_req;
  logic        frame_valid;
  logic        cam_reset_bar;
  logic        cam_trigger;
  logic        busy;
  logic        frame_done;
  logic        timeout_err;
  logic [15:0] frame_count;
  logic [2:0]  seq_state;

  modport master (
    output rst_req, trig_req, frame_valid,
    input  cam_reset_bar, cam_trigger, busy, frame_done, timeout_err, frame_count, seq_state
  );

  modport slave (
    input  rst_req, trig_req, frame_valid,
    output cam_reset_bar, cam_trigger, busy, frame_done, timeout_err, frame_count, seq_state
  );
endinterface

// File: rtl/mt9v034_seq.sv
// MT9V034 snapshot-mode sequencer: timed reset/boot, trigger pulses, frame tracking with timeout.
// Optional free-running auto trigger is built when CAM_SEQ_AUTO_TRIG_EN is defined.
module mt9v034_seq #(
`ifdef CAM_SEQ_AUTO_TRIG_EN
  parameter int AUTO_PERIOD    = 2400000,
`endif
  parameter int RST_CYCLES     = 480,
  parameter int BOOT_CYCLES    = 24000,
  parameter int TRIG_CYCLES    = 24,
  parameter int TIMEOUT_CYCLES = 2400000
) (
  input  logic          clk_24M,
  input  logic          reset_n,
  mt9v034_seq_if.slave  cam
);

  typedef enum logic [2:0] {
    RST_HOLD   = 3'd0,
    BOOT       = 3'd1,
    IDLE       = 3'd2,
    TRIG       = 3'd3,
    WAIT_FV_HI = 3'd4,
    WAIT_FV_LO = 3'd5
  } state_t;

  localparam logic [23:0] RST_LOAD  = 24'(RST_CYCLES - 1);
  localparam logic [23:0] BOOT_LOAD = 24'(BOOT_CYCLES - 1);
  localparam logic [23:0] TRIG_LOAD = 24'(TRIG_CYCLES - 1);
  localparam logic [23:0] TMO_LOAD  = 24'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [23:0] cnt;
  logic [23:0] tcnt;
  logic        fv_s1, fv_s2;
  logic        trig_q, trig_prev;
  logic        cam_reset_bar_r, cam_trigger_r, busy_r, frame_done_r, timeout_err_r;
  logic [15:0] frame_count_r;
  logic        trig_edge, start_frame, tmo, in_frame;

  // trig_req is registered once before edge detection so cam_trigger rises two clocks after the edge.
  always_ff @(posedge clk_24M or negedge reset_n) begin
    if (!reset_n) begin
      fv_s1     <= 1'b0;
      fv_s2     <= 1'b0;
      trig_q    <= 1'b0;
      trig_prev <= 1'b0;
    end else begin
      fv_s1     <= cam.frame_valid;
      fv_s2     <= fv_s1;
      trig_q    <= cam.trig_req;
      trig_prev <= trig_q;
    end
  end

  assign trig_edge = trig_q & ~trig_prev;
  assign tmo       = (tcnt == 24'd0);
  assign in_frame  = (state == TRIG) || (state == WAIT_FV_HI) || (state == WAIT_FV_LO);

`ifdef CAM_SEQ_AUTO_TRIG_EN
  localparam logic [23:0] AUTO_LOAD = 24'(AUTO_PERIOD - 1);
  logic [23:0] acnt;

  assign start_frame = trig_edge | (acnt == 24'd0);

  // Restarted on every TRIG entry so the period is measured trigger to trigger; parks at zero.
  always_ff @(posedge clk_24M or negedge reset_n) begin
    if (!reset_n) begin
      acnt <= AUTO_LOAD;
    end else if (state == IDLE && start_frame && !cam.rst_req) begin
      acnt <= AUTO_LOAD;
    end else if (acnt != 24'd0) begin
      acnt <= acnt - 24'd1;
    end
  end
`else
  assign start_frame = trig_edge;
`endif

  always_ff @(posedge clk_24M or negedge reset_n) begin
    if (!reset_n) begin
      state           <= RST_HOLD;
      cnt             <= RST_LOAD;
      tcnt            <= 24'd0;
      cam_reset_bar_r <= 1'b0;
      cam_trigger_r   <= 1'b0;
      busy_r          <= 1'b1;
      frame_done_r    <= 1'b0;
      timeout_err_r   <= 1'b0;
      frame_count_r   <= 16'd0;
    end else begin
      frame_done_r <= 1'b0;
      if (in_frame && !tmo) begin
        tcnt <= tcnt - 24'd1;
      end
      if (cam.rst_req) begin
        state           <= RST_HOLD;
        cnt             <= RST_LOAD;
        cam_reset_bar_r <= 1'b0;
        cam_trigger_r   <= 1'b0;
        busy_r          <= 1'b1;
      end else begin
        case (state)
          RST_HOLD: begin
            if (cnt == 24'd0) begin
              state           <= BOOT;
              cnt             <= BOOT_LOAD;
              cam_reset_bar_r <= 1'b1;
            end else begin
              cnt <= cnt - 24'd1;
            end
          end
          BOOT: begin
            if (cnt == 24'd0) begin
              state  <= IDLE;
              busy_r <= 1'b0;
            end else begin
              cnt <= cnt - 24'd1;
            end
          end
          IDLE: begin
            if (start_frame) begin
              state         <= TRIG;
              cnt           <= TRIG_LOAD;
              tcnt          <= TMO_LOAD;
              timeout_err_r <= 1'b0;
              cam_trigger_r <= 1'b1;
              busy_r        <= 1'b1;
            end
          end
          TRIG: begin
            if (tmo) begin
              state         <= IDLE;
              cam_trigger_r <= 1'b0;
              busy_r        <= 1'b0;
              timeout_err_r <= 1'b1;
            end else if (cnt == 24'd0) begin
              state         <= WAIT_FV_HI;
              cam_trigger_r <= 1'b0;
            end else begin
              cnt <= cnt - 24'd1;
            end
          end
          WAIT_FV_HI: begin
            if (tmo) begin
              state         <= IDLE;
              busy_r        <= 1'b0;
              timeout_err_r <= 1'b1;
            end else if (fv_s2) begin
              state <= WAIT_FV_LO;
            end
          end
          WAIT_FV_LO: begin
            if (tmo) begin
              state         <= IDLE;
              busy_r        <= 1'b0;
              timeout_err_r <= 1'b1;
            end else if (!fv_s2) begin
              state         <= IDLE;
              busy_r        <= 1'b0;
              frame_done_r  <= 1'b1;
              frame_count_r <= frame_count_r + 16'd1;
            end
          end
          default: begin
            state           <= RST_HOLD;
            cnt             <= RST_LOAD;
            cam_reset_bar_r <= 1'b0;
            cam_trigger_r   <= 1'b0;
            busy_r          <= 1'b1;
          end
        endcase
      end
    end
  end

  assign cam.cam_reset_bar = cam_reset_bar_r;
  assign cam.cam_trigger   = cam_trigger_r;
  assign cam.busy          = busy_r;
  assign cam.frame_done    = frame_done_r;
  assign cam.timeout_err   = timeout_err_r;
  assign cam.frame_count   = frame_count_r;
  assign cam.seq_state     = state;

endmodule

// File: tb/tb_mt9v034_seq.sv
// Bench for mt9v034_seq with shortened timing parameters; expectations come from tick arithmetic
// relative to each trigger and an expected-count queue checked on every frame_done.
module tb_mt9v034_seq;
  localparam int RST   = 48;
  localparam int BOOT  = 400;
  localparam int TRIGW = 24;
  localparam int TMO   = 2000;

  logic clk_24M = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_24M = ~clk_24M;

  mt9v034_seq_if cam_if ();

  mt9v034_seq #(
    .RST_CYCLES    (RST),
    .BOOT_CYCLES   (BOOT),
    .TRIG_CYCLES   (TRIGW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_24M (clk_24M),
    .reset_n (reset_n),
    .cam     (cam_if)
  );

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_count = 16'd0;
  logic        exp_terr = 1'b0;

  always @(posedge clk_24M) cyc++;

  // Scoreboard: every frame_done must match the next expected count.
  always @(negedge clk_24M) begin
    if (reset_n && cam_if.frame_done === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL frame_done_unexpected got count=%0h required no pulse", cam_if.frame_count);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (cam_if.frame_count !== e) begin
          bad++;
          $display("FAIL frame_done_count got=%0h required=%0h", cam_if.frame_count, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk_24M);
  endtask

  task automatic test_reset();
    int c0;
    cam_if.rst_req = 1'b0;
    cam_if.trig_req = 1'b0;
    cam_if.frame_valid = 1'b0;
    reset_n = 1'b0;
    repeat (3) tick();
    total += 6;
    if (cam_if.cam_reset_bar !== 1'b0) begin bad++; $display("FAIL rst_reset_bar got=%b required=0", cam_if.cam_reset_bar); end
    if (cam_if.cam_trigger !== 1'b0) begin bad++; $display("FAIL rst_trigger got=%b required=0", cam_if.cam_trigger); end
    if (cam_if.busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b required=1", cam_if.busy); end
    if (cam_if.frame_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b required=0", cam_if.frame_done); end
    if (cam_if.timeout_err !== 1'b0) begin bad++; $display("FAIL rst_terr got=%b required=0", cam_if.timeout_err); end
    if (cam_if.frame_count !== 16'd0) begin bad++; $display("FAIL rst_count got=%0h required=0", cam_if.frame_count); end
    reset_n = 1'b1;
    c0 = cyc;
    for (int i = 0; i < RST + 10 && cam_if.cam_reset_bar !== 1'b1; i++) tick();
    total++;
    if (cyc - c0 !== RST) begin bad++; $display("FAIL powerup_reset_low got=%0d required=%0d", cyc - c0, RST); end
    for (int i = 0; i < BOOT + 10 && cam_if.busy !== 1'b0; i++) tick();
    total++;
    if (cyc - c0 !== RST + BOOT) begin bad++; $display("FAIL powerup_busy_fall got=%0d required=%0d", cyc - c0, RST + BOOT); end
  endtask

  // mode 0: normal frame, 1: frame_valid never rises, 2: frame_valid stuck high.
  task automatic frame_txn(input int delay, input int width, input int mode, input bit toggle_mid);
    int k_end, trig_err, terr_err, busy_err, done_seen, done_tick;
    logic prev_terr, e_trig, e_terr, e_busy;
    trig_err = 0; terr_err = 0; busy_err = 0; done_seen = 0; done_tick = -1;
    prev_terr = exp_terr;
    if (mode == 0) begin
      k_end = delay + width + 3;
      exp_count = exp_count + 16'd1;
      exp_q.push_back(exp_count);
    end else begin
      k_end = 2 + TMO;
    end
    cam_if.frame_valid = 1'b0;
    cam_if.trig_req = 1'b1;
    for (int k = 1; k <= k_end + 4; k++) begin
      tick();
      e_trig = (k >= 2 && k <= 1 + TRIGW);
      e_terr = (k < 2) ? prev_terr : (mode != 0 && k >= k_end);
      e_busy = (k >= 2 && k < k_end);
      if (cam_if.cam_trigger !== e_trig) trig_err++;
      if (cam_if.timeout_err !== e_terr) terr_err++;
      if (cam_if.busy !== e_busy) busy_err++;
      if (cam_if.frame_done === 1'b1) begin done_seen++; done_tick = k; end
      if (k == 5) cam_if.trig_req = 1'b0;
      if (toggle_mid && k == 30) cam_if.trig_req = 1'b1;
      if (toggle_mid && k == 33) cam_if.trig_req = 1'b0;
      if (mode == 0) cam_if.frame_valid = (k >= delay && k < delay + width);
      else if (mode == 2) cam_if.frame_valid = (k >= delay);
      else cam_if.frame_valid = 1'b0;
    end
    cam_if.frame_valid = 1'b0;
    exp_terr = (mode != 0);
    total += 6;
    if (trig_err != 0) begin bad++; $display("FAIL trig_shape mode=%0d got=%0d bad ticks required=0", mode, trig_err); end
    if (terr_err != 0) begin bad++; $display("FAIL timeout_flag mode=%0d got=%0d bad ticks required=0", mode, terr_err); end
    if (busy_err != 0) begin bad++; $display("FAIL busy_shape mode=%0d got=%0d bad ticks required=0", mode, busy_err); end
    if (done_seen != (mode == 0 ? 1 : 0)) begin bad++; $display("FAIL done_pulses mode=%0d got=%0d required=%0d", mode, done_seen, (mode == 0 ? 1 : 0)); end
    if (mode == 0 && done_tick != k_end) begin bad++; $display("FAIL done_latency got=%0d required=%0d", done_tick, k_end); end
    else if (mode != 0 && done_tick != -1) begin bad++; $display("FAIL done_latency got=%0d required=none", done_tick); end
    if (cam_if.frame_count !== exp_count) begin bad++; $display("FAIL frame_count got=%0h required=%0h", cam_if.frame_count, exp_count); end
  endtask

  task automatic test_basic_frame();
    frame_txn(50, 100, 0, 1'b0);
  endtask

  task automatic test_timeout();
    frame_txn(0, 0, 1, 1'b0);
    frame_txn(60, 40, 0, 1'b0);
    frame_txn(40, 0, 2, 1'b0);
    frame_txn(35, 20, 0, 1'b0);
  endtask

  task automatic test_ignore_edges();
    frame_txn(80, 60, 0, 1'b1);
  endtask

  task automatic test_rst_req();
    int rise_k;
    logic [15:0] cnt_before;
    cnt_before = exp_count;
    rise_k = 81 + RST;
    cam_if.trig_req = 1'b1;
    for (int k = 1; k <= rise_k + BOOT + 10; k++) begin
      tick();
      if (k == 80) begin total++; if (cam_if.cam_reset_bar !== 1'b1) begin bad++; $display("FAIL rstreq_before got=%b required=1", cam_if.cam_reset_bar); end end
      if (k == 81) begin total++; if (cam_if.cam_reset_bar !== 1'b0) begin bad++; $display("FAIL rstreq_low got=%b required=0", cam_if.cam_reset_bar); end end
      if (k == rise_k - 1) begin total++; if (cam_if.cam_reset_bar !== 1'b0) begin bad++; $display("FAIL rstreq_hold got=%b required=0", cam_if.cam_reset_bar); end end
      if (k == rise_k) begin total++; if (cam_if.cam_reset_bar !== 1'b1) begin bad++; $display("FAIL rstreq_release got=%b required=1", cam_if.cam_reset_bar); end end
      if (k == rise_k + BOOT - 1) begin total++; if (cam_if.busy !== 1'b1) begin bad++; $display("FAIL rstreq_boot_busy got=%b required=1", cam_if.busy); end end
      if (k >= rise_k + BOOT) begin total++; if (cam_if.busy !== 1'b0 || cam_if.cam_trigger !== 1'b0) begin bad++; $display("FAIL rstreq_idle k=%0d got busy=%b trig=%b required 0 0", k, cam_if.busy, cam_if.cam_trigger); end end
      if (k == 5) cam_if.trig_req = 1'b0;
      cam_if.frame_valid = (k >= 50 && k < 150);
      cam_if.rst_req = (k == 80);
      if (k == rise_k + 20) cam_if.trig_req = 1'b1;
      if (k == rise_k + 25) cam_if.trig_req = 1'b0;
    end
    total += 2;
    if (cam_if.frame_count !== cnt_before) begin bad++; $display("FAIL rstreq_count got=%0h required=%0h", cam_if.frame_count, cnt_before); end
    if (cam_if.timeout_err !== exp_terr) begin bad++; $display("FAIL rstreq_terr got=%b required=%b", cam_if.timeout_err, exp_terr); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      int m;
      m = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      frame_txn(int'($urandom_range(30, 200)), int'($urandom_range(10, 150)), m, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(1, 20)) tick();
    end
  endtask

  task automatic test_wrap();
    force dut.frame_count_r = 16'hFFFF;
    tick();
    release dut.frame_count_r;
    exp_count = 16'hFFFF;
    frame_txn(40, 30, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_timeout();
    test_ignore_edges();
    test_rst_req();
    test_random();
    test_wrap();
    repeat (5) tick();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL missing_frame_done got=%0d pending required=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mt9v034_seq.md
# mt9v034_seq

Snapshot-mode sequencer for the MT9V034 sensor, clocked from the 24 MHz sensor clock domain. It drives the sensor's active-low reset through a timed reset/boot sequence, converts debounced trigger requests into fixed-width trigger pulses, and tracks FRAME_VALID to report frame completion or timeout. It sits between the debounced button outputs and the camera pins, replacing direct button-to-pin wiring.

## Interface
- RST_CYCLES, 480: clocks `cam_reset_bar` is held low per reset sequence (20 µs at 24 MHz).
- BOOT_CYCLES, 24000: clocks waited after reset release before triggers are accepted (1 ms).
- TRIG_CYCLES, 24: width of each `cam_trigger` pulse in clocks.
- TIMEOUT_CYCLES, 2400000: maximum clocks from trigger start to frame end (100 ms).
- AUTO_PERIOD, 2400000: auto-trigger period in clocks (used only with CAM_SEQ_AUTO_TRIG_EN).
- clk_24M  input  1  sensor-domain clock, 24 MHz.
- reset_n  input  1  asynchronous, active-low block reset.
- rst_req  input  1  debounced camera-reset request, level, synchronous to `clk_24M`.
- trig_req  input  1  debounced trigger request, level; rising edge requests one frame.
- frame_valid  input  1  sensor FRAME_VALID, double-flop synchronized inside the block.
- cam_reset_bar  output  1  sensor RESET_BAR, active low.
- cam_trigger  output  1  sensor snapshot trigger, active high.
- busy  output  1  high in every state except IDLE.
- frame_done  output  1  one-clock pulse when a triggered frame ends.
- timeout_err  output  1  sticky; set on timeout, cleared on next accepted trigger.
- frame_count  output  16  completed frames, wraps 0xFFFF→0x0000.

## Operation
- States: RST_HOLD, BOOT, IDLE, TRIG, WAIT_FV_HI, WAIT_FV_LO.
- One 24-bit down-counter `cnt` is shared by all timed states; loaded on state entry.
- RST_HOLD: `cam_reset_bar`=0; after RST_CYCLES clocks → BOOT.
- BOOT: `cam_reset_bar`=1; after BOOT_CYCLES clocks → IDLE. Trigger edges arriving in RST_HOLD/BOOT are discarded, not queued.
- IDLE: on `trig_req` rising edge (registered previous value) → TRIG; clear `timeout_err`; load timeout counter (separate 24-bit, counts TIMEOUT_CYCLES from TRIG entry).
- TRIG: `cam_trigger`=1 for TRIG_CYCLES clocks → WAIT_FV_HI.
- WAIT_FV_HI: synchronized `frame_valid`=1 → WAIT_FV_LO.
- WAIT_FV_LO: synchronized `frame_valid`=0 → IDLE; pulse `frame_done`; `frame_count`+1 (modulo 2^16).
- Timeout expiring in TRIG, WAIT_FV_HI or WAIT_FV_LO → IDLE, `timeout_err`=1, no `frame_done`, count unchanged, `cam_trigger` dropped immediately.
- `rst_req` high in any state → RST_HOLD next clock; held high keeps the block in RST_HOLD with counter reloaded every clock; sequence restarts on release. `rst_req` has priority over every other transition. `frame_count` and `timeout_err` are not cleared by `rst_req`.
- Trigger edges during TRIG/WAIT states are ignored (no queueing).

## Timing
- Reset values (reset_n=0): state RST_HOLD, `cam_reset_bar`=0, `cam_trigger`=0, `busy`=1, `frame_done`=0, `timeout_err`=0, `frame_count`=0.
- All outputs registered; no combinational input-to-output path.
- `cam_trigger` rises 2 clocks after the `trig_req` rising edge (edge detect + state register).
- `frame_valid` synchronizer adds 2 clocks; `frame_done` asserts 3 clocks after the raw `frame_valid` fall.
- Power-up: first trigger accepted no earlier than RST_CYCLES+BOOT_CYCLES+1 clocks after reset_n release.
- Timeout check takes priority over frame_valid edge in the same clock.

## Configuration
- CAM_SEQ_AUTO_TRIG_EN defined: in IDLE, a free-running AUTO_PERIOD counter (restarted on each TRIG entry) also starts a frame when it expires; `trig_req` edges still work; timing measured TRIG-to-TRIG.
- Undefined: only `trig_req` edges start frames; auto counter absent from netlist.

## Test plan
- Release reset_n, no requests -> `cam_reset_bar` low exactly 480 clocks, `busy` falls after 24480 clocks total.
- `trig_req` edge in IDLE, model FV high 100 clocks starting 50 clocks after trigger -> 24-clock `cam_trigger`, one `frame_done`, `frame_count`=1.
- `trig_req` edge, FV never asserted -> `cam_trigger` 24 clocks, `timeout_err`=1 at 2400000 clocks, return to IDLE, count unchanged; next trigger clears flag.
- `rst_req` pulse during WAIT_FV_LO -> `cam_reset_bar` low next clock for 480 clocks, no `frame_done`, `frame_count` retained.
- Trigger edges during BOOT and WAIT_FV_HI -> ignored; exactly one frame recorded.
- Force `frame_count`=0xFFFF, complete one frame -> wraps to 0x0000; with CAM_SEQ_AUTO_TRIG_EN and AUTO_PERIOD=1000, FV model 200 clocks -> triggers every 1000 clocks.
